// File: rtl/join_match_unit.sv
// Matching-memory join stage: pairs left/right operand packets on the same node into one joined packet.
// Optional JOIN_FLUSH_EN adds a synchronous 'flush' input that empties the matching store.
module join_match_unit #(
   parameter int NODE_W = 7,
   parameter int DATA_W = 16,
   parameter int DEPTH  = 8,
   parameter int PKT_W  = 15 + NODE_W + DATA_W
) (
   input  logic                      CLK,
   input  logic                      MR_N,
`ifdef JOIN_FLUSH_EN
   input  logic                      flush,
`endif
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [PKT_W-1:0]          in_pkt,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [PKT_W+DATA_W-1:0]   out_pkt,
   output logic [$clog2(DEPTH):0]    occupancy
);

   localparam int AW = $clog2(DEPTH);

   logic [2:0]        in_hdr;
   logic [7:0]        in_gen;
   logic [NODE_W-1:0] in_node;
   logic              in_lr, in_wait, in_f1, in_f0;
   logic [DATA_W-1:0] in_data;

   assign in_data = in_pkt[DATA_W-1:0];
   assign in_f0   = in_pkt[DATA_W];
   assign in_f1   = in_pkt[DATA_W+1];
   assign in_wait = in_pkt[DATA_W+2];
   assign in_lr   = in_pkt[DATA_W+3];
   assign in_node = in_pkt[DATA_W+4 +: NODE_W];
   assign in_gen  = in_pkt[DATA_W+4+NODE_W +: 8];
   assign in_hdr  = in_pkt[DATA_W+12+NODE_W +: 3];

   logic flush_now;
`ifdef JOIN_FLUSH_EN
   assign flush_now = flush;
`else
   assign flush_now = 1'b0;
`endif

   // The joined packet takes its flags from the arriving packet, so only node/lr/data are kept per entry
   logic [DEPTH-1:0]  ent_valid;
   logic [DEPTH-1:0]  ent_lr;
   logic [NODE_W-1:0] ent_node [DEPTH];
   logic [DATA_W-1:0] ent_data [DEPTH];

   logic [DEPTH-1:0]  eff_valid, next_valid;
   logic [AW:0]       eff_occ, next_occ;
   logic              hit, free_found;
   logic [AW-1:0]     hit_idx, free_idx;
   logic              accept, emit, store_new, take_hit;
   logic [DATA_W-1:0] data_left, data_right;

   // Search runs against the store as it will look after a same-cycle flush, lowest index winning
   always_comb begin
      eff_valid  = flush_now ? '0 : ent_valid;
      eff_occ    = flush_now ? '0 : occupancy;
      hit        = 1'b0;
      hit_idx    = '0;
      free_found = 1'b0;
      free_idx   = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (eff_valid[i] && ent_node[i] == in_node && ent_lr[i] != in_lr) begin
            hit     = 1'b1;
            hit_idx = AW'(i);
         end
         if (!eff_valid[i]) begin
            free_found = 1'b1;
            free_idx   = AW'(i);
         end
      end
   end

   assign in_ready  = MR_N && (!out_valid || out_ready) && (free_found || !in_wait || hit);
   assign accept    = in_valid && in_ready;
   assign take_hit  = accept && in_wait && hit;
   assign store_new = accept && in_wait && !hit;
   assign emit      = accept && (!in_wait || hit);

   always_comb begin
      next_valid = eff_valid;
      next_occ   = eff_occ;
      data_left  = in_data;
      data_right = '0;
      if (store_new) begin
         next_valid[free_idx] = 1'b1;
         next_occ             = eff_occ + (AW+1)'(1);
      end
      if (take_hit) begin
         next_valid[hit_idx] = 1'b0;
         next_occ            = eff_occ - (AW+1)'(1);
         if (in_lr) begin
            data_left  = ent_data[hit_idx];
            data_right = in_data;
         end else begin
            data_right = ent_data[hit_idx];
         end
      end
   end

   always_ff @(posedge CLK or negedge MR_N) begin
      if (!MR_N) begin
         ent_valid <= '0;
         ent_lr    <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            ent_node[i] <= '0;
            ent_data[i] <= '0;
         end
         occupancy <= '0;
         out_valid <= 1'b0;
         out_pkt   <= '0;
      end else begin
         ent_valid <= next_valid;
         occupancy <= next_occ;
         if (store_new) begin
            ent_node[free_idx] <= in_node;
            ent_lr[free_idx]   <= in_lr;
            ent_data[free_idx] <= in_data;
         end
         if (emit) begin
            out_valid <= 1'b1;
            out_pkt   <= {in_hdr, in_gen, in_node, 1'b0, in_wait, in_f1, in_f0, data_left, data_right};
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule
